// File: rtl/dmem_responder.sv
// Memory-side responder for the processor bus: tagged LOAD/STORE acceptance and a fixed-latency load return pipe.
// Optional DMEM_STALL_INJECT_EN adds LFSR-driven pseudo-random refusal of commands.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       proc2mem_command,
    input  logic [31:0]      proc2mem_addr,
    input  logic [31:0]      proc2mem_data,
    input  logic [1:0]       proc2mem_size,
    output logic [TAG_W-1:0] mem2proc_response,
    output logic [TAG_W-1:0] mem2proc_tag,
    output logic [31:0]      mem2proc_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;

    localparam logic [TAG_W-1:0] TAG_ONE = {{(TAG_W-1){1'b0}}, 1'b1};
    localparam logic [TAG_W-1:0] TAG_MAX = {TAG_W{1'b1}};

    logic [31:0]      mem [DEPTH_WORDS];
    logic [AW-1:0]    word_idx;
    logic             is_load;
    logic             is_store;
    logic             accept_ok;
    logic             accept;
    logic [TAG_W-1:0] next_tag;
    logic [3:0]       byte_en;
    logic [31:0]      rd_word;
    logic [TAG_W-1:0] ins_tag;
    logic [31:0]      ins_data;

    logic [TAG_W-1:0] pipe_tag  [LATENCY];
    logic [31:0]      pipe_data [LATENCY];

    // Upper address bits alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^proc2mem_addr[31:AW+2];

    assign word_idx = proc2mem_addr[AW+1:2];
    assign is_load  = (proc2mem_command == BUS_LOAD);
    assign is_store = (proc2mem_command == BUS_STORE);

`ifdef DMEM_STALL_INJECT_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Free-running so the refusal pattern depends only on time since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    assign accept_ok = (lfsr[1:0] != 2'b00);
`else
    assign accept_ok = 1'b1;
`endif

    // Handshake: a LOAD/STORE is taken exactly in the cycle mem2proc_response
    // is nonzero (its value is the tag); otherwise the requester must hold the
    // command unchanged and retry next cycle. Load completions are pushed with
    // no backpressure: mem2proc_tag != 0 marks valid mem2proc_data.
    assign accept            = (is_load || is_store) && accept_ok;
    assign mem2proc_response = accept ? next_tag : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_tag <= TAG_ONE;
        end else if (accept) begin
            next_tag <= (next_tag == TAG_MAX) ? TAG_ONE : next_tag + TAG_ONE;
        end
    end

    always_comb begin
        byte_en = 4'b0000;
        case (proc2mem_size)
            SIZE_BYTE: byte_en = 4'b0001 << proc2mem_addr[1:0];
            SIZE_HALF: byte_en = proc2mem_addr[1] ? 4'b1100 : 4'b0011;
            default:   byte_en = 4'b1111;
        endcase
    end

    // Storage is intentionally not reset; committed stores survive rst.
    always_ff @(posedge clk) begin
        if (accept && is_store) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][b*8 +: 8] <= proc2mem_data[b*8 +: 8];
                end
            end
        end
    end

    // Read happens in the accept cycle, so it sees every earlier store.
    assign rd_word  = mem[word_idx];
    assign ins_tag  = (accept && is_load) ? next_tag : '0;
    assign ins_data = (accept && is_load) ? rd_word  : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag[i]  <= '0;
                pipe_data[i] <= 32'h0;
            end
        end else begin
            pipe_tag[0]  <= ins_tag;
            pipe_data[0] <= ins_data;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_tag[i]  <= pipe_tag[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // Bubbles carry zero data, so data is never stale when tag is 0.
    assign mem2proc_tag  = pipe_tag[LATENCY-1];
    assign mem2proc_data = pipe_data[LATENCY-1];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: stores, loads, byte lanes, tag wrap and reset.
// Builds with or without DMEM_STALL_INJECT_EN; the bench models the refusal LFSR itself.
module tb_dmem_responder;

    localparam int LATENCY = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  proc2mem_command = 2'd0;
    logic [31:0] proc2mem_addr = 32'h0;
    logic [31:0] proc2mem_data = 32'h0;
    logic [1:0]  proc2mem_size = 2'd0;
    logic [3:0]  mem2proc_response;
    logic [3:0]  mem2proc_tag;
    logic [31:0] mem2proc_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] tb_lfsr;
    int          exp_tag = 1;

    logic [3:0]  due_tag  [1024];
    logic [31:0] due_data [1024];

    logic [1:0]  c_cmd  [128];
    logic [31:0] c_addr [128];
    logic [31:0] c_data [128];
    logic [1:0]  c_size [128];
    logic [31:0] c_exp  [128];
    int          n_cmds = 0;

    dmem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY(LATENCY),
        .TAG_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .proc2mem_size(proc2mem_size),
        .mem2proc_response(mem2proc_response),
        .mem2proc_tag(mem2proc_tag),
        .mem2proc_data(mem2proc_data)
    );

    // ---------------- clock / reset / reference models ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) tb_lfsr <= 16'hACE1;
        else     tb_lfsr <= {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
    end

    function automatic bit exp_ok();
`ifdef DMEM_STALL_INJECT_EN
        return (tb_lfsr[1:0] != 2'b00);
`else
        return 1'b1;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] cmd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] size);
        proc2mem_command = cmd;
        proc2mem_addr    = addr;
        proc2mem_data    = data;
        proc2mem_size    = size;
        #1;
    endtask

    task automatic add(input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] size, input logic [31:0] exp);
        c_cmd[n_cmds]  = cmd;
        c_addr[n_cmds] = addr;
        c_data[n_cmds] = data;
        c_size[n_cmds] = size;
        c_exp[n_cmds]  = exp;
        n_cmds++;
    endtask

    task automatic clear_due();
        for (int i = 0; i < 1024; i++) begin
            due_tag[i]  = 4'd0;
            due_data[i] = 32'h0;
        end
    endtask

    // Runs the command table one command per cycle (holding refused ones),
    // checking response, completion tag and completion data every cycle.
    task automatic exec_table(input string name, input int max_cycles);
        int         idx;
        int         budget;
        int         last_due;
        int         slot;
        bit         is_mem;
        logic [3:0] exp_resp;
        idx      = 0;
        budget   = 0;
        last_due = cyc;
        while ((idx < n_cmds || cyc <= last_due) && budget < max_cycles) begin
            @(negedge clk);
            slot = cyc % 1024;
            n_tests++;
            if (mem2proc_tag !== due_tag[slot]) begin
                $display("FAIL %s tag cyc=%0d got=%0d want=%0d", name, cyc, mem2proc_tag, due_tag[slot]);
                n_fail++;
            end
            n_tests++;
            if (mem2proc_data !== due_data[slot]) begin
                $display("FAIL %s data cyc=%0d got=%h want=%h", name, cyc, mem2proc_data, due_data[slot]);
                n_fail++;
            end
            due_tag[slot]  = 4'd0;
            due_data[slot] = 32'h0;
            if (idx < n_cmds) begin
                drive(c_cmd[idx], c_addr[idx], c_data[idx], c_size[idx]);
                is_mem   = (c_cmd[idx] == 2'd1) || (c_cmd[idx] == 2'd2);
                exp_resp = (is_mem && exp_ok()) ? 4'(exp_tag) : 4'd0;
                n_tests++;
                if (mem2proc_response !== exp_resp) begin
                    $display("FAIL %s response idx=%0d got=%0d want=%0d", name, idx, mem2proc_response, exp_resp);
                    n_fail++;
                end
                if (!is_mem || exp_resp != 4'd0) begin
                    if (c_cmd[idx] == 2'd1) begin
                        slot           = (cyc + LATENCY) % 1024;
                        due_tag[slot]  = 4'(exp_tag);
                        due_data[slot] = c_exp[idx];
                        last_due       = cyc + LATENCY;
                    end else if (last_due < cyc + 1) begin
                        last_due = cyc + 1;
                    end
                    if (exp_resp != 4'd0) exp_tag = (exp_tag == 15) ? 1 : exp_tag + 1;
                    idx++;
                end
            end else begin
                drive(2'd0, 32'h0, 32'h0, 2'd0);
            end
            budget++;
        end
        n_tests++;
        if (idx < n_cmds || cyc <= last_due) begin
            $display("FAIL %s budget expired idx=%0d of %0d", name, idx, n_cmds);
            n_fail++;
        end
        drive(2'd0, 32'h0, 32'h0, 2'd0);
        n_cmds = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (mem2proc_tag !== 4'd0 || mem2proc_data !== 32'h0) begin
                $display("FAIL reset_hold tag=%0d data=%h want 0/0", mem2proc_tag, mem2proc_data);
                n_fail++;
            end
        end
        rst = 1'b0;
        exp_tag = 1;
        clear_due();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(2'd0, 32'h0, 32'h0, 2'd0);
            n_tests++;
            if (mem2proc_response !== 4'd0 || mem2proc_tag !== 4'd0 || mem2proc_data !== 32'h0) begin
                $display("FAIL reset_idle resp=%0d tag=%0d data=%h want 0/0/0", mem2proc_response, mem2proc_tag, mem2proc_data);
                n_fail++;
            end
        end
    endtask

    task automatic test_store_load();
        add(2'd2, 32'h0000_0040, 32'hCAFE_F00D, 2'd2, 32'h0);
        add(2'd1, 32'h0000_0040, 32'h0, 2'd0, 32'hCAFE_F00D);
        add(2'd1, 32'h0000_1040, 32'h0, 2'd0, 32'hCAFE_F00D);      // alias modulo 4 KiB
        add(2'd3, 32'h0000_0040, 32'hDEAD_BEEF, 2'd2, 32'h0);      // reserved: no store
        add(2'd0, 32'h0000_0040, 32'hDEAD_BEEF, 2'd2, 32'h0);
        add(2'd1, 32'h0000_0040, 32'h0, 2'd0, 32'hCAFE_F00D);
        exec_table("store_load", 200);
    endtask

    task automatic test_byte_lanes();
        add(2'd2, 32'h0000_0080, 32'h1122_3344, 2'd2, 32'h0);
        add(2'd2, 32'h0000_0082, 32'h00AB_0000, 2'd0, 32'h0);
        add(2'd1, 32'h0000_0080, 32'h0, 2'd0, 32'h11AB_3344);
        add(2'd2, 32'h0000_0080, 32'h0000_BEEF, 2'd1, 32'h0);
        add(2'd1, 32'h0000_0080, 32'h0, 2'd0, 32'h11AB_BEEF);
        add(2'd2, 32'h0000_0083, 32'h1234_0000, 2'd1, 32'h0);      // addr[0] ignored for half
        add(2'd1, 32'h0000_0082, 32'h0, 2'd2, 32'h1234_BEEF);
        add(2'd2, 32'h0000_0081, 32'h0000_5500, 2'd0, 32'h0);
        add(2'd1, 32'h0000_0080, 32'h0, 2'd0, 32'h1234_55EF);
        add(2'd2, 32'h0000_0084, 32'hA5A5_5A5A, 2'd3, 32'h0);      // size 3 = word
        add(2'd1, 32'h0000_0084, 32'h0, 2'd0, 32'hA5A5_5A5A);
        exec_table("byte_lanes", 200);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) add(2'd2, 32'h200 + 32'(i * 4), 32'hD000_0000 + 32'(i), 2'd2, 32'h0);
        exec_table("b2b_fill", 200);
        // Reset so the load tags start from 1; storage must survive it.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_tag = 1;
        clear_due();
        for (int i = 0; i < 20; i++) add(2'd1, 32'h200 + 32'(i * 4), 32'h0, 2'd0, 32'hD000_0000 + 32'(i));
        exec_table("b2b_load", 300);
    endtask

    task automatic test_reset_in_flight();
        @(negedge clk);
        drive(2'd1, 32'h0000_0040, 32'h0, 2'd0);
        @(negedge clk);
        drive(2'd1, 32'h0000_0044, 32'h0, 2'd0);
        @(negedge clk);
        drive(2'd0, 32'h0, 32'h0, 2'd0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            n_tests++;
            if (mem2proc_tag !== 4'd0 || mem2proc_data !== 32'h0) begin
                $display("FAIL rst_in_flight i=%0d tag=%0d data=%h want 0/0", i, mem2proc_tag, mem2proc_data);
                n_fail++;
            end
        end
        exp_tag = 1;
        clear_due();
        add(2'd1, 32'h0000_0040, 32'h0, 2'd0, 32'hCAFE_F00D);
        exec_table("rst_in_flight_reload", 200);
    endtask

`ifdef DMEM_STALL_INJECT_EN
    task automatic test_stall();
        add(2'd2, 32'h0000_0000, 32'h5EED_0001, 2'd2, 32'h0);
        for (int i = 0; i < 64; i++) add(2'd1, 32'h0000_0000, 32'h0, 2'd0, 32'h5EED_0001);
        exec_table("stall", 400);
    endtask
`endif

    initial begin
        clear_due();
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_back_to_back();
        test_reset_in_flight();
`ifdef DMEM_STALL_INJECT_EN
        test_stall();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
